// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-extension pipeline.
package imm_pkg;

    localparam int unsigned IMM_IN_W      = 25;
    localparam int unsigned ILLEGAL_CNT_W = 16;

    // Immediate format select encodings.
    typedef enum logic [2:0] {
        ImmI       = 3'b000,
        ImmS       = 3'b001,
        ImmU       = 3'b010,
        ImmZ       = 3'b011,
        ImmSh      = 3'b100,
        ImmB       = 3'b101,
        ImmJ       = 3'b110,
        ImmIllegal = 3'b111
    } imm_src_e;

endpackage

// File: rtl/imm_format.sv
// Combinational immediate decoder: instruction bits [31:7] -> XLEN-wide immediate.
module imm_format
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [IMM_IN_W-1:0] imm_in_i,
    input  imm_src_e            imm_src_i,
    output logic [XLEN-1:0]     imm_ext_o,
    output logic                illegal_o
);

    logic        sign;
    logic        sext;
    logic [31:0] val32;

    assign sign = imm_in_i[24];

    // Build the low 32 bits per format and record whether the top is sign- or zero-filled.
    always_comb begin
        val32     = '0;
        sext      = 1'b0;
        illegal_o = 1'b0;
        unique case (imm_src_i)
            ImmI: begin
                val32 = {{20{sign}}, imm_in_i[24:13]};
                sext  = 1'b1;
            end
            ImmS: begin
                val32 = {{20{sign}}, imm_in_i[24:18], imm_in_i[4:0]};
                sext  = 1'b1;
            end
            ImmB: begin
                val32 = {{19{sign}}, imm_in_i[24], imm_in_i[0], imm_in_i[23:18],
                         imm_in_i[4:1], 1'b0};
                sext  = 1'b1;
            end
            ImmU: begin
                val32 = {imm_in_i[24:5], 12'b0};
                sext  = 1'b1;
            end
            ImmJ: begin
                val32 = {{11{sign}}, imm_in_i[24], imm_in_i[12:5], imm_in_i[13],
                         imm_in_i[23:14], 1'b0};
                sext  = 1'b1;
            end
            ImmZ: begin
                val32 = {27'b0, imm_in_i[12:8]};
            end
            ImmSh: begin
                // RV64 shift amounts carry one extra bit.
                if (XLEN == 64) begin
                    val32 = {26'b0, imm_in_i[18:13]};
                end else begin
                    val32 = {27'b0, imm_in_i[17:13]};
                end
            end
            ImmIllegal: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    // Widen to XLEN; the loop is empty when XLEN is 32.
    always_comb begin
        imm_ext_o       = '0;
        imm_ext_o[31:0] = val32;
        for (int i = 32; i < int'(XLEN); i++) begin
            imm_ext_o[i] = sext & val32[31];
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extender with a two-entry (main + skid) valid/ready output buffer.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [IMM_IN_W-1:0]      ImmIn,
    input  logic [2:0]               ImmSrc,
    input  logic [TAG_W-1:0]         InTag,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [XLEN-1:0]          ImmExt,
    output logic [TAG_W-1:0]         OutTag,
    output logic                     IllegalSrc,
    output logic [ILLEGAL_CNT_W-1:0] IllegalCount
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } entry_t;

    entry_t                   new_entry;
    entry_t                   main_q, main_d, skid_q, skid_d;
    logic                     main_valid_q, main_valid_d;
    logic                     skid_valid_q, skid_valid_d;
    logic                     in_ready_q, in_ready_d;
    logic [ILLEGAL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic                     accept, drain;

    imm_format #(
        .XLEN (XLEN)
    ) u_imm_format (
        .imm_in_i  (ImmIn),
        .imm_src_i (imm_src_e'(ImmSrc)),
        .imm_ext_o (new_entry.imm),
        .illegal_o (new_entry.ill)
    );

    assign new_entry.tag = InTag;

    assign accept = InValid && in_ready_q;
    assign drain  = main_valid_q && OutReady;

    // Buffer next-state. in_ready_q mirrors !skid_valid_q, so accept never coincides with a full skid.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = new_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end
        end
        in_ready_d = !skid_valid_d;
    end

    // Illegal-request counter, bumped on acceptance and held at all-ones.
    always_comb begin
        ill_cnt_d = ill_cnt_q;
        if (accept && new_entry.ill && (ill_cnt_q != '1)) begin
            ill_cnt_d = ill_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            ill_cnt_q    <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            ill_cnt_q    <= ill_cnt_d;
        end
    end

    assign InReady      = in_ready_q;
    assign OutValid     = main_valid_q;
    assign ImmExt       = main_q.imm;
    assign OutTag       = main_q.tag;
    assign IllegalSrc   = main_q.ill;
    assign IllegalCount = ill_cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe at XLEN=32 and XLEN=64 driven in lockstep.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [24:0] imm_in;
    logic [2:0]  imm_src;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] ext32;
    logic [4:0]  tag32;
    logic [15:0] cnt32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] ext64;
    logic [4:0]  tag64;
    logic [15:0] cnt64;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .InValid(in_valid), .InReady(in_ready32),
        .ImmIn(imm_in), .ImmSrc(imm_src), .InTag(in_tag), .OutValid(out_valid32),
        .OutReady(out_ready), .ImmExt(ext32), .OutTag(tag32), .IllegalSrc(ill32),
        .IllegalCount(cnt32)
    );

    imm_ext_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .InValid(in_valid), .InReady(in_ready64),
        .ImmIn(imm_in), .ImmSrc(imm_src), .InTag(in_tag), .OutValid(out_valid64),
        .OutReady(out_ready), .ImmExt(ext64), .OutTag(tag64), .IllegalSrc(ill64),
        .IllegalCount(cnt64)
    );

    typedef struct {
        logic [24:0] imm_in;
        logic [2:0]  src;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        ill;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [4:0] got_tags[$];
    logic       drop_valid;
    logic [31:0] held;

    initial begin
        vecs[0]  = '{25'h1FFE000, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{25'h1000001, 3'b101, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0};
        vecs[2]  = '{25'h1000000, 3'b010, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[3]  = '{25'h1001F00, 3'b011, 32'h0000001F, 64'h000000000000001F, 1'b0};
        vecs[4]  = '{25'h014000A, 3'b001, 32'h000000AA, 64'h00000000000000AA, 1'b0};
        vecs[5]  = '{25'h1FC001F, 3'b001, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[6]  = '{25'h0002000, 3'b110, 32'h00000800, 64'h0000000000000800, 1'b0};
        vecs[7]  = '{25'h0001FE0, 3'b110, 32'h000FF000, 64'h00000000000FF000, 1'b0};
        vecs[8]  = '{25'h1000000, 3'b110, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
        vecs[9]  = '{25'h107E000, 3'b100, 32'h0000001F, 64'h000000000000003F, 1'b0};
        vecs[10] = '{25'h0246000, 3'b000, 32'h00000123, 64'h0000000000000123, 1'b0};
        vecs[11] = '{25'h1FFFFFF, 3'b111, 32'h00000000, 64'h0000000000000000, 1'b1};
        vecs[12] = '{25'h0FC001E, 3'b101, 32'h000007FE, 64'h00000000000007FE, 1'b0};

        // Reset with InValid high: it must be ignored.
        rst_n = 1'b0; in_valid = 1'b1; imm_in = 25'h1FFFFFF; imm_src = 3'b111;
        in_tag = 5'd9; out_ready = 1'b1;
        tick();
        chk("rst_outvalid", {62'b0, out_valid32, out_valid64}, 64'd0);
        chk("rst_inready", {62'b0, in_ready32, in_ready64}, 64'd3);
        chk("rst_count", {32'b0, cnt32, cnt64}, 64'd0);
        chk("rst_immext32", {32'b0, ext32}, 64'd0);
        chk("rst_immext64", ext64, 64'd0);
        chk("rst_tag_ill", {52'b0, tag32, tag64, ill32, ill64}, 64'd0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        tick();

        // Format table, one result per cycle with OutReady held high.
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1; imm_in = vecs[i].imm_in; imm_src = vecs[i].src;
            in_tag = 5'(i);
            tick();
            chk($sformatf("vec%0d_valid", i), {62'b0, out_valid32, out_valid64}, 64'd3);
            chk($sformatf("vec%0d_x32", i), {32'b0, ext32}, {32'b0, vecs[i].e32});
            chk($sformatf("vec%0d_x64", i), ext64, vecs[i].e64);
            chk($sformatf("vec%0d_tag", i), {54'b0, tag32, tag64}, {54'b0, 5'(i), 5'(i)});
            chk($sformatf("vec%0d_ill", i), {62'b0, ill32, ill64}, {62'b0, vecs[i].ill, vecs[i].ill});
        end
        in_valid = 1'b0;
        tick();
        chk("tbl_count", {32'b0, cnt32, cnt64}, {32'b0, 16'd1, 16'd1});
        chk("tbl_drained", {62'b0, out_valid32, out_valid64}, 64'd0);

        // Three back-to-back illegal requests.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; imm_in = 25'h0ABCDEF; imm_src = 3'b111; in_tag = 5'(i);
            tick();
            chk($sformatf("ill%0d_valid", i), {63'b0, out_valid64}, 64'd1);
            chk($sformatf("ill%0d_ext", i), ext64 | {32'b0, ext32}, 64'd0);
            chk($sformatf("ill%0d_flag", i), {62'b0, ill32, ill64}, 64'd3);
            chk($sformatf("ill%0d_tag", i), {59'b0, tag64}, {59'b0, 5'(i)});
        end
        in_valid = 1'b0;
        tick();
        chk("ill_count", {32'b0, cnt32, cnt64}, {32'b0, 16'd3, 16'd3});

        // Saturation: keep feeding illegal requests well past 16'hFFFF.
        in_valid = 1'b1;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("sat_count", {32'b0, cnt32, cnt64}, {32'b0, 16'hFFFF, 16'hFFFF});

        // Backpressure: tags 1,2 fill main+skid, tag 3 waits on the input.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'b000;
        imm_in = 25'h0002000; in_tag = 5'd1;
        tick();
        chk("bp_t1_valid", {63'b0, out_valid32}, 64'd1);
        chk("bp_t1_ready", {63'b0, in_ready32}, 64'd1);
        imm_in = 25'h0004000; in_tag = 5'd2;
        tick();
        chk("bp_full_ready", {62'b0, in_ready32, in_ready64}, 64'd0);
        chk("bp_hold_tag", {59'b0, tag32}, 64'd1);
        held = ext32;
        imm_in = 25'h0006000; in_tag = 5'd3;
        tick();
        chk("bp_still_full", {63'b0, in_ready32}, 64'd0);
        chk("bp_hold_ext", {32'b0, ext32}, {32'b0, held});
        chk("bp_hold_tag2", {59'b0, tag32}, 64'd1);
        out_ready = 1'b1;
        drop_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid32) begin
                got_tags.push_back(tag32);
                chk($sformatf("bp_ext_k%0d", k), {32'b0, ext32}, {59'b0, tag32});
            end
            if (in_valid && in_ready32 && in_tag == 5'd3) drop_valid = 1'b1;
            tick();
            if (drop_valid) in_valid = 1'b0;
        end
        chk("bp_count", 64'(got_tags.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got_tags.size())
                chk($sformatf("bp_order%0d", k), {59'b0, got_tags[k]}, 64'(k + 1));
        end

        // Reset with two entries buffered.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'b111; in_tag = 5'd4;
        tick();
        in_tag = 5'd5;
        tick();
        chk("mr_full", {62'b0, in_ready32, in_ready64}, 64'd0);
        chk("mr_cnt_pre", {48'b0, cnt64}, 64'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        chk("mr_outvalid", {62'b0, out_valid32, out_valid64}, 64'd0);
        chk("mr_inready", {62'b0, in_ready32, in_ready64}, 64'd3);
        chk("mr_count", {32'b0, cnt32, cnt64}, 64'd0);
        out_ready = 1'b1;
        tick();
        chk("mr_no_ghost", {62'b0, out_valid32, out_valid64}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning output immediate width; legal values are 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 5, meaning the width of the sideband tag passed through alongside each immediate.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port InValid, input, 1 bit: the upstream request is valid.
REQ-006 SHALL have port InReady, output, 1 bit: the block can accept a request this cycle.
REQ-007 SHALL have port ImmIn, input, 25 bits: instruction bits [31:7] (ImmIn[24] = instr[31]).
REQ-008 SHALL have port ImmSrc, input, 3 bits: immediate format select.
REQ-009 SHALL have port InTag, input, TAG_W bits: sideband tag, passed through unmodified.
REQ-010 SHALL have port OutValid, output, 1 bit: the result is valid.
REQ-011 SHALL have port OutReady, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port ImmExt, output, XLEN bits: the extended immediate.
REQ-013 SHALL have port OutTag, output, TAG_W bits: the tag belonging to ImmExt.
REQ-014 SHALL have port IllegalSrc, output, 1 bit: the current result came from an illegal ImmSrc; qualified by OutValid.
REQ-015 SHALL have port IllegalCount, output, 16 bits: saturating count of accepted illegal requests.

Function
REQ-016 SHALL decode ImmSrc as follows; every format except Z, SH and illegal is sign-extended from ImmIn[24] to XLEN:
- 000 I: ImmIn[24:13].
- 001 S: {ImmIn[24:18], ImmIn[4:0]}.
- 101 B: {ImmIn[24], ImmIn[0], ImmIn[23:18], ImmIn[4:1], 0}.
- 010 U: ImmIn[24:5] << 12.
- 110 J: {ImmIn[24], ImmIn[12:5], ImmIn[13], ImmIn[23:14], 0}.
REQ-017 SHALL, for 011 Z (CSR uimm), output ImmIn[12:8] zero-extended.
REQ-018 SHALL, for 100 SH (shamt), output ImmIn[18:13] zero-extended when XLEN=64, and ImmIn[17:13] zero-extended when XLEN=32.
REQ-019 SHALL, for 111 (illegal), output ImmExt=0 with IllegalSrc=1.
REQ-020 SHALL accept a request only on a cycle where InValid && InReady are both high.
REQ-021 SHALL deliver a result on a cycle where OutValid && OutReady are both high.
REQ-022 SHALL present an accepted request on its outputs with OutValid=1 exactly one cycle after acceptance when the output stage is empty or draining.
REQ-023 SHALL sustain one result per cycle while OutReady=1.
REQ-024 SHALL contain a 2-entry buffer made of a main register and a skid register; outputs always come from the main register.
REQ-025 SHALL drive InReady from a register, with InReady = NOT skid-full.
REQ-026 SHALL, if a request is accepted while the main register is valid and not draining, place it in the skid register; InReady then falls on the next cycle.
REQ-027 SHALL move the skid entry into the main register on the cycle the main entry drains; InReady rises on the next cycle.
REQ-028 SHALL, if accept and drain occur together with the skid empty, load the new entry directly into the main register with no bubble.
REQ-029 SHALL hold ImmExt, OutTag and IllegalSrc stable while OutValid && !OutReady.
REQ-030 SHALL preserve order: no loss, no duplication, no reordering.
REQ-031 SHALL increment IllegalCount on acceptance of ImmSrc=111, not on delivery, and SHALL saturate it at 16'hFFFF.

Reset
REQ-032 SHALL, on a clock edge with rst_n=0, clear both buffer entries: OutValid=0, InReady=1, IllegalCount=0, ImmExt=0, OutTag=0, IllegalSrc=0.
REQ-033 SHALL discard all in-flight entries when reset is asserted mid-operation, and SHALL ignore InValid during reset.

Structure
REQ-034 SHALL place the following in package imm_pkg: typedef enum imm_src_e (the 3-bit encodings above), constants IMM_IN_W=25 and ILLEGAL_CNT_W=16.
REQ-035 SHALL implement format decode as a purely combinational sub-module imm_format, parameterised by XLEN; imm_ext_pipe holds only the buffer, handshake and counter.

Verification
REQ-036 SHALL test I-type sign extension: XLEN=32, ImmIn=25'h1FFE000, ImmSrc=000, OutReady=1 -> the next cycle gives OutValid=1 and ImmExt=32'hFFFFFFFF.
REQ-037 SHALL test B-type at XLEN=64: ImmIn with only bits 24 and 0 set, ImmSrc=101 -> ImmExt=64'hFFFFFFFFFFFFF800.
REQ-038 SHALL test U-type and Z-type at XLEN=64: ImmIn=25'h1000000, ImmSrc=010 -> ImmExt=64'hFFFFFFFF80000000; then ImmIn=25'h1001F00, ImmSrc=011 -> ImmExt=64'h1F.
REQ-039 SHALL test backpressure: OutReady=0, tags 1 and 2 accepted -> InReady=0 on the following cycle; tag 3 is held on the input; with OutReady=1, OutTag sequence is 1,2,3 with no gaps or duplicates.
REQ-040 SHALL test illegal handling: three accepted ImmSrc=111 requests -> each result has ImmExt=0 and IllegalSrc=1, and IllegalCount=3.
REQ-041 SHALL test reset mid-operation: with 2 entries buffered, rst_n=0 for one edge -> OutValid=0, InReady=1, IllegalCount=0 on the next cycle.
